// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: requester indices and sizing helper shared by the RAM arbiter
package ram_arbiter_pkg;
  localparam int REQ_FETCH = 0;
  localparam int REQ_LSU = 1;
  function automatic int log2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter with an inhibit that blocks the grant and freezes the pointer
module rr_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = log2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               inhibit,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] ptr;
  logic hit;
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i]) begin idx = IW'(i); hit = 1'b1; end
    for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i] && IW'(i) >= ptr) idx = IW'(i);
    gnt = (hit && !inhibit && reset_n) ? NUM_REQ'(1) << idx : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (|gnt) ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one registered-read dual-port RAM between NUM_REQ requesters
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        rd_req,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
  output logic [NUM_REQ-1:0]        rd_gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  input  logic [NUM_REQ-1:0]        wr_req,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        wr_gnt,
  output logic [ADDR_W-1:0]         ram_read_addr,
  output logic [ADDR_W-1:0]         ram_write_addr,
  output logic                      ram_write,
  output logic [DATA_W-1:0]         ram_in,
  input  logic [DATA_W-1:0]         ram_out
);
  localparam int IW = log2(NUM_REQ);
  logic [ADDR_W-1:0] ra [NUM_REQ];
  logic [ADDR_W-1:0] wa [NUM_REQ];
  logic [DATA_W-1:0] wd [NUM_REQ];
  logic [IW-1:0] rd_idx, wr_idx;
  logic hazard;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign ra[g] = rd_addr[g*ADDR_W +: ADDR_W];
    assign wa[g] = wr_addr[g*ADDR_W +: ADDR_W];
    assign wd[g] = wr_data[g*DATA_W +: DATA_W];
  end
  // a read of the address being written waits a cycle so it returns the new data
  assign hazard = |rd_req && |wr_req && ra[rd_idx] == wa[wr_idx];
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd (
    .clk(clk), .reset_n(reset_n), .req(rd_req), .inhibit(hazard), .gnt(rd_gnt), .idx(rd_idx)
  );
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr (
    .clk(clk), .reset_n(reset_n), .req(wr_req), .inhibit(1'b0), .gnt(wr_gnt), .idx(wr_idx)
  );
  always_comb begin
    ram_write = |wr_gnt;
    ram_write_addr = ram_write ? wa[wr_idx] : '0;
    ram_in = ram_write ? wd[wr_idx] : '0;
    ram_read_addr = |rd_gnt ? ra[rd_idx] : '0;
  end
  assign rd_data = ram_out;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rd_valid <= '0;
    else rd_valid <= rd_gnt;
endmodule
